fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-bypass and hazard unit for the ID->EX boundary of an in-order
// pipeline. The unit tracks the destination tags of the instructions in
// flight in a small shift register. Entry 0 is EX, entry 1 is MEM and
// entry 2 is WB for the default depth. From those tags it
//   * picks forwarded EX operands, with the youngest producer taking priority,
//   * raises the ID stall for load-use, and for the no-forwarding mode,
//   * keeps a saturating count of stalled cycles.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst          : synchronous, active-high reset
//   bypass_en    : 1 = forwarding on, 0 = stall until write-back
//   flush        : kills the instruction currently in ID
//   id_valid     : ID holds a real instruction
//   id_rs        : ID source indices, slot i = [i*RW +: RW]
//   id_rs_used   : per-source read enable
//   id_rd        : ID destination index
//   id_we        : ID instruction writes id_rd
//   id_load      : ID instruction is a load
//   ex_reg_data  : register-file operands latched into EX
//   stg_data     : write-back value of stage k, held in slot k-1
//   ex_opnd      : EX operands after bypass
//   fwd_hit      : operand i was forwarded
//   stall        : hold IF/ID and insert a bubble into EX
//   stall_cnt    : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int WIDTH      = 16,
  parameter int RW         = 3,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bypass_en,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NSRC*RW-1:0]         id_rs,
  input  logic [NSRC-1:0]            id_rs_used,
  input  logic [RW-1:0]              id_rd,
  input  logic                       id_we,
  input  logic                       id_load,
  input  logic [NSRC*WIDTH-1:0]      ex_reg_data,
  input  logic [(DEPTH-1)*WIDTH-1:0] stg_data,
  output logic [NSRC*WIDTH-1:0]      ex_opnd,
  output logic [NSRC-1:0]            fwd_hit,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cnt
);

  // Tag entries: index 0 = EX, increasing toward write-back.
  logic [DEPTH-1:0]         r_ent_valid;
  logic [DEPTH-1:0]         r_ent_we;
  logic [DEPTH-1:0]         r_ent_load;
  logic [DEPTH-1:0][RW-1:0] r_ent_rd;

  // Source tags of the instruction currently in EX.
  logic [NSRC*RW-1:0]       r_ex_rs;
  logic [NSRC-1:0]          r_ex_used;

  logic [CNT_W-1:0]         r_stall_cnt;

  logic [DEPTH-1:0]         w_live;       // entry can produce a match
  logic [NSRC-1:0]          w_src_stall;  // per-source hazard in ID
  logic                     w_stall;
  logic                     w_issue;      // ID instruction moves into EX

  // A bubble or a non-writing instruction never matches anything.
  assign w_live = r_ent_valid & r_ent_we;

  // ---------------------------------------------------------------------------
  // Forwarding. Scanning from the oldest stage toward the youngest lets the
  // last hit win, which gives the youngest producer priority.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it holding state (no latch).
  always_comb begin
    ex_opnd = ex_reg_data;
    fwd_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (bypass_en && r_ex_used[i] && w_live[k] &&
            (r_ent_rd[k] == r_ex_rs[i*RW +: RW])) begin
          ex_opnd[i*WIDTH +: WIDTH] = stg_data[(k-1)*WIDTH +: WIDTH];
          fwd_hit[i]                = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall. With bypass on, only the youngest matching producer matters: it
  // stalls if its value is not yet forwardable one stage from now. With bypass
  // off, any producer short of WB stalls, since the write-through register
  // file already exposes the WB value to the ID read.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_src_stall = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (id_rs_used[i] && w_live[j] &&
            (r_ent_rd[j] == id_rs[i*RW +: RW])) begin
          if (bypass_en)
            w_src_stall[i] = (j + 1) < (r_ent_load[j] ? LOAD_READY : 1);
          else
            w_src_stall[i] = w_src_stall[i] | (j <= DEPTH - 2);
        end
      end
    end
  end

  // An empty ID slot has nothing to protect; flush and reset always win.
  assign w_stall = id_valid & (|w_src_stall) & ~flush & ~rst;
  assign w_issue = id_valid & ~w_stall & ~flush;

  // ---------------------------------------------------------------------------
  // Control state: validity, used bits and the counter.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which keeps the shift register ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent_valid <= '0;
      r_ex_used   <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++)
        r_ent_valid[k] <= r_ent_valid[k-1];
      r_ent_valid[0] <= w_issue;
      r_ex_used      <= w_issue ? id_rs_used : '0;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag payload. It is qualified by the valid and used bits above.
  // ---------------------------------------------------------------------------
  // NOTE: payload fields are deliberately not reset; a cleared valid/used bit
  // makes their contents irrelevant and saves reset routing.
  always_ff @(posedge clk) begin
    for (int k = 1; k < DEPTH; k++) begin
      r_ent_rd[k]   <= r_ent_rd[k-1];
      r_ent_we[k]   <= r_ent_we[k-1];
      r_ent_load[k] <= r_ent_load[k-1];
    end
    r_ent_rd[0]   <= id_rd;
    r_ent_we[0]   <= id_we;
    r_ent_load[0] <= id_load;
    r_ex_rs       <= id_rs;
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit (defaults, except CNT_W = 4). Stimulus
// tasks drive ID/EX inputs just after a rising edge. In the same step they
// push the hand-computed expected values into a scoreboard queue, tagged with
// the current cycle. A monitor samples on the falling edge, pops every entry
// due that cycle and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int WIDTH = 16;
  localparam int RW    = 3;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {K_STALL, K_HIT, K_OP0, K_OP1, K_CNT} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       bypass_en;
  logic                       flush;
  logic                       id_valid;
  logic [NSRC*RW-1:0]         id_rs;
  logic [NSRC-1:0]            id_rs_used;
  logic [RW-1:0]              id_rd;
  logic                       id_we;
  logic                       id_load;
  logic [NSRC*WIDTH-1:0]      ex_reg_data;
  logic [(DEPTH-1)*WIDTH-1:0] stg_data;
  logic [NSRC*WIDTH-1:0]      ex_opnd;
  logic [NSRC-1:0]            fwd_hit;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  fwd_hazard_unit #(
    .WIDTH(WIDTH), .RW(RW), .NSRC(NSRC), .DEPTH(DEPTH),
    .LOAD_READY(2), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bypass_en  (bypass_en),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_load    (id_load),
    .ex_reg_data(ex_reg_data),
    .stg_data   (stg_data),
    .ex_opnd    (ex_opnd),
    .fwd_hit    (fwd_hit),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: actual=no finish required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_STALL: act = {31'd0, stall};
        K_HIT:   act = {30'd0, fwd_hit};
        K_OP0:   act = {16'd0, ex_opnd[15:0]};
        K_OP1:   act = {16'd0, ex_opnd[31:16]};
        default: act = {28'd0, stall_cnt};
      endcase
      if (e.cyc != cyc) check({e.name, "_late"}, cyc, e.cyc);
      else              check(e.name, act, e.val);
    end
  end

  task automatic expect_v(input kind_e k, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [RW-1:0] rs0,
                       input logic [RW-1:0] rs1, input logic [1:0] used,
                       input logic [RW-1:0] rd, input logic we, input logic ld);
    id_valid   = v;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_we      = we;
    id_load    = ld;
  endtask

  task automatic idle;
    issue(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    idle();
    flush     = 1'b0;
    bypass_en = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bypass_en   = 1'b1;
    flush       = 1'b0;
    ex_reg_data = {16'h00BB, 16'h00AA};
    stg_data    = {16'h5555, 16'h4444};
    idle();
    tick();

    // Reset state
    do_reset();
    expect_v(K_STALL, 0, "rst_stall");
    expect_v(K_HIT, 0, "rst_hit");
    expect_v(K_OP0, 16'h00AA, "rst_op0");
    expect_v(K_OP1, 16'h00BB, "rst_op1");
    expect_v(K_CNT, 0, "rst_cnt");

    // 1. ALU back-to-back: ADD r3 ; SUB reads r3
    issue(1, 0, 0, 2'b00, 3, 1, 0);
    expect_v(K_STALL, 0, "alu_stall_a");
    tick();
    issue(1, 3, 0, 2'b01, 6, 1, 0);
    expect_v(K_STALL, 0, "alu_stall_b");
    tick();
    idle();
    stg_data = {16'h5555, 16'h1234};
    expect_v(K_OP0, 16'h1234, "alu_op0");
    expect_v(K_OP1, 16'h00BB, "alu_op1");
    expect_v(K_HIT, 2'b01, "alu_hit");
    expect_v(K_CNT, 0, "alu_cnt");
    tick();

    // 2. Load-use: LD r2 ; ADD reads r2
    do_reset();
    issue(1, 0, 0, 2'b00, 2, 1, 1);
    expect_v(K_STALL, 0, "lu_stall_a");
    tick();
    issue(1, 2, 0, 2'b01, 7, 1, 0);
    expect_v(K_STALL, 1, "lu_stall_b");
    expect_v(K_CNT, 0, "lu_cnt_b");
    tick();
    expect_v(K_STALL, 0, "lu_stall_c");
    expect_v(K_CNT, 1, "lu_cnt_c");
    tick();
    idle();
    stg_data = {16'hBEEF, 16'h4444};
    expect_v(K_OP0, 16'hBEEF, "lu_op0");
    expect_v(K_HIT, 2'b01, "lu_hit");
    expect_v(K_CNT, 1, "lu_cnt_d");
    tick();

    // 3. Youngest priority: ADD r1 ; ADD r1 ; consumer reads r1 twice
    do_reset();
    issue(1, 0, 0, 2'b00, 1, 1, 0);
    tick();
    issue(1, 0, 0, 2'b00, 1, 1, 0);
    tick();
    issue(1, 1, 1, 2'b11, 6, 1, 0);
    expect_v(K_STALL, 0, "yp_stall");
    tick();
    idle();
    stg_data = {16'h0001, 16'h0002};
    expect_v(K_OP0, 16'h0002, "yp_op0");
    expect_v(K_OP1, 16'h0002, "yp_op1");
    expect_v(K_HIT, 2'b11, "yp_hit");
    tick();

    // 4. No-forward mode: ADD r4 ; consumer reads r4 -> 2 stalls
    do_reset();
    bypass_en = 1'b0;
    issue(1, 0, 0, 2'b00, 4, 1, 0);
    tick();
    issue(1, 4, 0, 2'b01, 5, 1, 0);
    expect_v(K_STALL, 1, "nf_stall_1");
    tick();
    expect_v(K_STALL, 1, "nf_stall_2");
    expect_v(K_CNT, 1, "nf_cnt_2");
    tick();
    expect_v(K_STALL, 0, "nf_stall_3");
    expect_v(K_CNT, 2, "nf_cnt_3");
    tick();
    idle();
    expect_v(K_HIT, 0, "nf_hit");
    expect_v(K_OP0, 16'h00AA, "nf_op0");
    tick();

    // 4b. Bypass disabled combinationally while a match sits in MEM
    do_reset();
    issue(1, 0, 0, 2'b00, 4, 1, 0);
    tick();
    issue(1, 4, 0, 2'b01, 5, 1, 0);
    tick();
    idle();
    stg_data  = {16'h5555, 16'h1234};
    bypass_en = 1'b0;
    expect_v(K_HIT, 0, "bpoff_hit");
    expect_v(K_OP0, 16'h00AA, "bpoff_op0");
    expect_v(K_STALL, 0, "bpoff_stall");
    tick();

    // Producer with we=0 never matches; r0 is an ordinary register
    do_reset();
    issue(1, 0, 0, 2'b00, 0, 0, 1);
    tick();
    issue(1, 0, 0, 2'b01, 5, 1, 0);
    expect_v(K_STALL, 0, "we0_stall");
    tick();
    issue(1, 0, 0, 2'b00, 0, 1, 1);
    tick();
    issue(1, 0, 0, 2'b01, 5, 1, 0);
    expect_v(K_STALL, 1, "r0_load_stall");
    tick();
    idle();
    tick();

    // 5. Flush beats stall: LD r5 in EX, consumer in ID with flush
    do_reset();
    issue(1, 0, 0, 2'b00, 5, 1, 1);
    tick();
    issue(1, 5, 0, 2'b01, 6, 1, 0);
    flush = 1'b1;
    expect_v(K_STALL, 0, "fl_stall");
    expect_v(K_CNT, 0, "fl_cnt_b");
    tick();
    flush = 1'b0;
    idle();
    stg_data = {16'h5555, 16'h1234};
    expect_v(K_HIT, 0, "fl_bubble_hit");
    expect_v(K_OP0, 16'h00AA, "fl_bubble_op0");
    expect_v(K_CNT, 0, "fl_cnt_c");
    tick();

    // 6. Saturation and reset: chained r4 <- r4 with bypass off
    do_reset();
    bypass_en = 1'b0;
    issue(1, 4, 0, 2'b01, 4, 1, 0);
    expect_v(K_STALL, 0, "sat_stall_0");
    tick();
    expect_v(K_STALL, 1, "sat_stall_1");
    tick();
    tick();
    expect_v(K_STALL, 0, "sat_stall_3");
    expect_v(K_CNT, 2, "sat_cnt_3");
    for (int n = 0; n < 31; n++) tick();
    expect_v(K_STALL, 1, "sat_stall_34");
    expect_v(K_CNT, 15, "sat_cnt_34");
    tick();
    rst = 1'b1;
    expect_v(K_STALL, 0, "sat_rst_stall");
    expect_v(K_CNT, 15, "sat_rst_cnt_hold");
    tick();
    rst = 1'b0;
    expect_v(K_CNT, 0, "sat_post_cnt");
    expect_v(K_STALL, 0, "sat_post_stall");
    expect_v(K_HIT, 0, "sat_post_hit");
    expect_v(K_OP0, 16'h00AA, "sat_post_op0");
    tick();
    idle();
    tick();
    tick();

    if (sb.size() != 0) check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
